// File: rtl/sram6116_pkg.sv
// Shared types and constants for the AXI4-Lite to 6116 (2Kx8) SRAM bridge.
package sram6116_pkg;

  localparam int unsigned SRAM_AW   = 11;
  localparam int unsigned NUM_LANES = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_STROBE,
    B_RESP,
    R_RESP
  } state_e;

  // Lowest enabled byte lane; callers guarantee strb is nonzero.
  function automatic logic [1:0] first_lane(logic [NUM_LANES-1:0] strb);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (strb[i]) lane = 2'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/sram6116_byte_seq.sv
// Per-byte strobe timer and SRAM control-pin decode for the 6116 bridge.
module sram6116_byte_seq
  import sram6116_pkg::*;
#(
  parameter int unsigned WaitStates = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  state_e state_i,
  output logic   strobe_done_o,
  output logic   ce_n_o,
  output logic   we_n_o,
  output logic   oe_n_o,
  output logic   dq_oe_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       strobe;

  assign strobe        = (state_i == WR_STROBE) || (state_i == RD_STROBE);
  assign strobe_done_o = strobe && (cnt_q == 4'(WaitStates - 1));

  // Counter restarts after each completed strobe so back-to-back read lanes get full width.
  always_comb begin
    cnt_d = 4'd0;
    if (strobe && !strobe_done_o) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= 4'd0;
    else         cnt_q <= cnt_d;
  end

  // Pins decode straight from state, so reset releases we_n at the same edge.
  assign dq_oe_o = (state_i == WR_SETUP) || (state_i == WR_STROBE) || (state_i == WR_HOLD);
  assign ce_n_o  = !(dq_oe_o || (state_i == RD_STROBE));
  assign we_n_o  = (state_i != WR_STROBE);
  assign oe_n_o  = (state_i != RD_STROBE);

endmodule

// File: rtl/sram6116_axil_slave.sv
// AXI4-Lite slave exposing a 6116 2Kx8 SRAM as 512 32-bit words.
// Define SRAM6116_AXIL_SLVERR_EN to answer SLVERR for addresses above 2 KB.
module sram6116_axil_slave
  import sram6116_pkg::*;
#(
  parameter int unsigned WAIT_STATES        = 2,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [SRAM_AW-1:0]              sram_addr,
  output logic [7:0]                      sram_dq_o,
  input  logic [7:0]                      sram_dq_i,
  output logic                            sram_dq_oe,
  output logic                            sram_ce_n,
  output logic                            sram_we_n,
  output logic                            sram_oe_n
);

  state_e                  state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [SRAM_AW-3:0]      addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_LANES-1:0]    wstrb_q, wstrb_d, strb_left;
  logic [1:0]              resp_q, resp_d;
  logic                    ar_accept, aw_accept, ar_err, aw_err, strobe_done;

`ifdef SRAM6116_AXIL_SLVERR_EN
  logic unused_in;
  assign ar_err    = |ARADDR[C_S_AXI_ADDR_WIDTH-1:SRAM_AW];
  assign aw_err    = |AWADDR[C_S_AXI_ADDR_WIDTH-1:SRAM_AW];
  assign unused_in = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
`else
  logic unused_in;
  assign ar_err    = 1'b0;
  assign aw_err    = 1'b0;
  assign unused_in = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0],
                       AWADDR[C_S_AXI_ADDR_WIDTH-1:SRAM_AW], ARADDR[C_S_AXI_ADDR_WIDTH-1:SRAM_AW]};
`endif

  // Reads win in IDLE; a write needs AW and W together. Gated by reset so no handshake is lost.
  assign ar_accept = ARESETN && (state_q == IDLE) && ARVALID;
  assign aw_accept = ARESETN && (state_q == IDLE) && !ARVALID && AWVALID && WVALID;
  assign ARREADY   = ar_accept;
  assign AWREADY   = aw_accept;
  assign WREADY    = aw_accept;

  assign BVALID    = (state_q == B_RESP);
  assign RVALID    = (state_q == R_RESP);
  assign BRESP     = resp_q;
  assign RRESP     = resp_q;
  assign RDATA     = rdata_q;
  assign sram_addr = {addr_q, lane_q};
  assign sram_dq_o = wdata_q[8*lane_q +: 8];
  assign strb_left = wstrb_q & ~(4'b0001 << lane_q);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (ar_accept) begin
          addr_d  = ARADDR[SRAM_AW-1:2];
          lane_d  = 2'd0;
          rdata_d = 32'd0;
          resp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
          state_d = ar_err ? R_RESP : RD_STROBE;
        end else if (aw_accept) begin
          addr_d  = AWADDR[SRAM_AW-1:2];
          wdata_d = WDATA;
          wstrb_d = WSTRB;
          lane_d  = first_lane(WSTRB);
          resp_d  = aw_err ? RESP_SLVERR : RESP_OKAY;
          state_d = (aw_err || WSTRB == '0) ? B_RESP : WR_SETUP;
        end
      end
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: if (strobe_done) state_d = WR_HOLD;
      WR_HOLD: begin
        wstrb_d = strb_left;
        if (strb_left == '0) begin
          state_d = B_RESP;
        end else begin
          lane_d  = first_lane(strb_left);
          state_d = WR_SETUP;
        end
      end
      RD_STROBE: begin
        if (strobe_done) begin
          rdata_d[8*lane_q +: 8] = sram_dq_i;
          if (lane_q == 2'(NUM_LANES - 1)) state_d = R_RESP;
          else                             lane_d  = lane_q + 2'd1;
        end
      end
      B_RESP:  if (BREADY) state_d = IDLE;
      R_RESP:  if (RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= '0;
      rdata_q <= 32'd0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  sram6116_byte_seq #(
    .WaitStates(WAIT_STATES)
  ) u_byte_seq (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .state_i      (state_q),
    .strobe_done_o(strobe_done),
    .ce_n_o       (sram_ce_n),
    .we_n_o       (sram_we_n),
    .oe_n_o       (sram_oe_n),
    .dq_oe_o      (sram_dq_oe)
  );

endmodule

// File: tb/tb_sram6116_axil_slave.sv
// Directed bench for sram6116_axil_slave with a behavioural 6116 model, WAIT_STATES=2.
module tb_sram6116_axil_slave;

  logic        tb_ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic [10:0] sram_addr;
  logic [7:0]  sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;

  logic [7:0]  mem [0:2047];
  int          we_pulses = 0;
  int          ce_cycles = 0;
  logic        we_prev = 1'b1;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  sram6116_axil_slave #(
    .WAIT_STATES       (2),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32)
  ) dut (
    .ACLK      (tb_ACLK),
    .ARESETN   (ARESETN),
    .AWADDR    (AWADDR),
    .AWPROT    (AWPROT),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .ARADDR    (ARADDR),
    .ARPROT    (ARPROT),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n (sram_ce_n),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  // SRAM model works mid-cycle so it never races the DUT's clock edge.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

  always @(negedge tb_ACLK) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_o;
    if (!sram_ce_n) ce_cycles <= ce_cycles + 1;
    we_prev <= sram_we_n;
    if (we_prev && !sram_we_n) we_pulses <= we_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic aw_issue(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int t;
    @(negedge tb_ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    t = 0;
    while (!(AWREADY && WREADY) && t < 100) begin
      @(negedge tb_ACLK);
      t++;
    end
    if (!(AWREADY && WREADY)) check("aw_timeout", {31'd0, AWREADY}, 32'd1);
    @(negedge tb_ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic wait_b(output int lat);
    lat = 1;
    while (!BVALID && lat < 200) begin
      @(negedge tb_ACLK);
      lat++;
    end
    if (!BVALID) check("b_timeout", {31'd0, BVALID}, 32'd1);
  endtask

  task automatic b_ack(output logic [1:0] resp);
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge tb_ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    aw_issue(addr, data, strb);
    wait_b(lat);
    b_ack(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int t;
    @(negedge tb_ACLK);
    ARADDR = addr; ARVALID = 1'b1;
    #1;
    t = 0;
    while (!ARREADY && t < 100) begin
      @(negedge tb_ACLK);
      t++;
    end
    if (!ARREADY) check("ar_timeout", {31'd0, ARREADY}, 32'd1);
    @(negedge tb_ACLK);
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < 200) begin
      @(negedge tb_ACLK);
      lat++;
    end
    if (!RVALID) check("r_timeout", {31'd0, RVALID}, 32'd1);
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge tb_ACLK);
    RREADY = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          lat, snap, t;
    logic        hold_ok, aw_seen;

    ARESETN = 1'b0; AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
    AWPROT = '0; ARPROT = '0; AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    repeat (3) @(negedge tb_ACLK);
    check("rst_ready", {29'd0, ARREADY, AWREADY, WREADY}, 32'd0);
    check("rst_valid", {30'd0, BVALID, RVALID}, 32'd0);
    check("rst_resp",  {28'd0, BRESP, RRESP}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_pins",  {28'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b1110);
    check("rst_addr",  {13'd0, sram_addr, sram_dq_o}, 32'd0);
    ARESETN = 1'b1;

    axi_write(32'h0, 32'h0101FFFF, 4'hF, rsp, lat);
    check("w0_bresp", {30'd0, rsp}, 32'd0);
    check("w0_lat", lat, 32'd17);
    axi_read(32'h0, rd, rsp, lat);
    check("r0_data", rd, 32'h0101FFFF);
    check("r0_rresp", {30'd0, rsp}, 32'd0);
    check("r0_lat", lat, 32'd9);

    axi_write(32'h4, 32'habcd0001, 4'hF, rsp, lat);
    axi_write(32'h8, 32'hdead0011, 4'hF, rsp, lat);
    axi_write(32'hC, 32'hbeef0011, 4'hF, rsp, lat);
    axi_read(32'h4, rd, rsp, lat); check("r4_data", rd, 32'habcd0001);
    axi_read(32'h8, rd, rsp, lat); check("r8_data", rd, 32'hdead0011);
    axi_read(32'hC, rd, rsp, lat); check("rC_data", rd, 32'hbeef0011);

    axi_write(32'h10, 32'h11223344, 4'hF, rsp, lat);
    snap = we_pulses;
    axi_write(32'h10, 32'hAABBCCDD, 4'b0101, rsp, lat);
    check("strb_lat", lat, 32'd9);
    check("strb_we_pulses", we_pulses - snap, 32'd2);
    axi_read(32'h10, rd, rsp, lat); check("strb_data", rd, 32'h11BB33DD);

    snap = we_pulses;
    axi_write(32'h8, 32'hFFFFFFFF, 4'b0000, rsp, lat);
    check("strb0_lat", lat, 32'd1);
    check("strb0_no_we", we_pulses - snap, 32'd0);
    axi_read(32'h8, rd, rsp, lat); check("strb0_data", rd, 32'hdead0011);

    // Read and write offered together: the read must be served first.
    @(negedge tb_ACLK);
    ARADDR = 32'h4; ARVALID = 1'b1;
    AWADDR = 32'h4; WDATA = 32'h5A5A1234; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    check("both_arready", {31'd0, ARREADY}, 32'd1);
    check("both_awready", {31'd0, AWREADY}, 32'd0);
    @(negedge tb_ACLK);
    ARVALID = 1'b0;
    aw_seen = 1'b0; t = 0;
    while (!RVALID && t < 100) begin
      aw_seen = aw_seen | AWREADY | BVALID;
      @(negedge tb_ACLK);
      t++;
    end
    check("both_rvalid", {31'd0, RVALID}, 32'd1);
    check("both_w_waits", {31'd0, aw_seen}, 32'd0);
    check("both_rdata", RDATA, 32'habcd0001);
    RREADY = 1'b1;
    @(negedge tb_ACLK);
    RREADY = 1'b0;
    check("both_aw_after", {31'd0, AWREADY}, 32'd1);
    @(negedge tb_ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_b(lat);
    b_ack(rsp);
    axi_read(32'h4, rd, rsp, lat); check("both_wdata", rd, 32'h5A5A1234);

    // Response back-pressure: BVALID holds and a new write is refused.
    aw_issue(32'h40, 32'h01234567, 4'hF);
    wait_b(lat);
    AWADDR = 32'h44; WDATA = 32'h76543210; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    hold_ok = 1'b1; aw_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_ACLK);
      hold_ok = hold_ok & BVALID;
      aw_seen = aw_seen | AWREADY | WREADY;
    end
    check("bp_bvalid_held", {31'd0, hold_ok}, 32'd1);
    check("bp_no_aw", {31'd0, aw_seen}, 32'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    b_ack(rsp);
    check("bp_bresp", {30'd0, rsp}, 32'd0);

    // Reset in the middle of a write strobe.
    aw_issue(32'h30, 32'h77777777, 4'hF);
    t = 0;
    while (sram_we_n && t < 50) begin
      @(negedge tb_ACLK);
      t++;
    end
    check("mid_we_low", {31'd0, sram_we_n}, 32'd0);
    ARESETN = 1'b0;
    @(negedge tb_ACLK);
    check("mid_pins", {28'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b1110);
    check("mid_valid", {27'd0, BVALID, RVALID, ARREADY, AWREADY, WREADY}, 32'd0);
    check("mid_addr", {13'd0, sram_addr, sram_dq_o}, 32'd0);
    check("mid_rdata", RDATA, 32'd0);
    ARESETN = 1'b1;
    axi_read(32'h0, rd, rsp, lat);
    check("post_rst_data", rd, 32'h0101FFFF);
    check("post_rst_lat", lat, 32'd9);

    snap = ce_cycles;
    axi_read(32'h800, rd, rsp, lat);
`ifdef SRAM6116_AXIL_SLVERR_EN
    check("oob_rresp", {30'd0, rsp}, 32'h2);
    check("oob_rdata", rd, 32'd0);
    check("oob_no_ce", ce_cycles - snap, 32'd0);
    check("oob_lat", lat, 32'd1);
`else
    check("wrap_rresp", {30'd0, rsp}, 32'd0);
    check("wrap_rdata", rd, 32'h0101FFFF);
    check("wrap_ce", ce_cycles - snap, 32'd8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
